// File: rtl/tcp_rx_session_reader_if.sv
// ----------------------------------------------------------------------------
// tcp_rx_session_reader_if
//
// Bundles the handshake and stream channels of tcp_rx_session_reader.
// Signal names keep the original s_/m_ prefixes as seen from the reader.
//
//   s_notif_*   TCP notification in   (valid/data in, ready out)
//   m_readpkg_* read-package request  (valid/data out, ready in)
//   s_rxmeta_*  rx metadata in        (valid/data in, ready out)
//   s_rxdata_*  rx payload stream in  (valid/data/keep/last in, ready out)
//   m_ep_*      endpoint stream out   (valid/data/keep/last out, ready in)
//
// Modports:
//   master : the environment around the reader (TCP stack + endpoint)
//   slave  : the reader itself
// ----------------------------------------------------------------------------
interface tcp_rx_session_reader_if #(
  parameter int unsigned DATA_WIDTH = 512
) ();

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  // Notification channel
  logic                  s_notif_valid;
  logic                  s_notif_ready;
  logic [87:0]           s_notif_data;

  // Read-package request channel
  logic                  m_readpkg_valid;
  logic                  m_readpkg_ready;
  logic [31:0]           m_readpkg_data;

  // Rx metadata channel
  logic                  s_rxmeta_valid;
  logic                  s_rxmeta_ready;
  logic [15:0]           s_rxmeta_data;

  // Rx payload stream
  logic                  s_rxdata_valid;
  logic                  s_rxdata_ready;
  logic                  s_rxdata_last;
  logic [DATA_WIDTH-1:0] s_rxdata_data;
  logic [KEEP_WIDTH-1:0] s_rxdata_keep;

  // Endpoint stream
  logic                  m_ep_valid;
  logic                  m_ep_ready;
  logic                  m_ep_last;
  logic [DATA_WIDTH-1:0] m_ep_data;
  logic [KEEP_WIDTH-1:0] m_ep_keep;

  modport master (
    output s_notif_valid,  s_notif_data,
    input  s_notif_ready,
    input  m_readpkg_valid, m_readpkg_data,
    output m_readpkg_ready,
    output s_rxmeta_valid, s_rxmeta_data,
    input  s_rxmeta_ready,
    output s_rxdata_valid, s_rxdata_last, s_rxdata_data, s_rxdata_keep,
    input  s_rxdata_ready,
    input  m_ep_valid, m_ep_last, m_ep_data, m_ep_keep,
    output m_ep_ready
  );

  modport slave (
    input  s_notif_valid,  s_notif_data,
    output s_notif_ready,
    output m_readpkg_valid, m_readpkg_data,
    input  m_readpkg_ready,
    input  s_rxmeta_valid, s_rxmeta_data,
    output s_rxmeta_ready,
    input  s_rxdata_valid, s_rxdata_last, s_rxdata_data, s_rxdata_keep,
    output s_rxdata_ready,
    output m_ep_valid, m_ep_last, m_ep_data, m_ep_keep,
    input  m_ep_ready
  );

endinterface

// File: rtl/tcp_rx_session_reader.sv
// ----------------------------------------------------------------------------
// tcp_rx_session_reader
//
// Turns TCP receive notifications into read-package requests, then forwards
// the matching rx payload to the endpoint preceded by one header beat that
// carries {port, ip, length, session} in bits [79:0].
// Empty or closed notifications are dropped and counted. A metadata session
// differing from the request and a payload byte count differing from the
// notified length raise sticky error flags. Only one request is outstanding:
// notifications are accepted in IDLE only.
//
// Ports:
//   net_clk      clock
//   net_aresetn  synchronous active-low reset
//   bus          handshake/stream channels (tcp_rx_session_reader_if.slave)
//   drop_cnt     notifications dropped (length 0 or closed)
//   pkt_cnt      packets fully forwarded
//   err_session  sticky: metadata session differed from the request
//   err_length   sticky: payload byte count differed from the notified length
// ----------------------------------------------------------------------------
module tcp_rx_session_reader #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                       net_clk,
  input  logic                       net_aresetn,
  tcp_rx_session_reader_if.slave     bus,
  output logic [CNT_WIDTH-1:0]       drop_cnt,
  output logic [CNT_WIDTH-1:0]       pkt_cnt,
  output logic                       err_session,
  output logic                       err_length
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    META,
    HDR,
    DATA
  } state_e;

  state_e                state_q,       state_d;
  logic [15:0]           session_q,     session_d;
  logic [15:0]           length_q,      length_d;
  logic [31:0]           ip_q,          ip_d;
  logic [15:0]           port_q,        port_d;
  logic [16:0]           byte_cnt_q,    byte_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q,    drop_cnt_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q,     pkt_cnt_d;
  logic                  err_session_q, err_session_d;
  logic                  err_length_q,  err_length_d;

  // Combinational channel outputs
  logic                  notif_ready;
  logic                  rp_valid;
  logic [31:0]           rp_data;
  logic                  meta_ready;
  logic                  rx_ready;
  logic                  ep_valid;
  logic                  ep_last;
  logic [DATA_WIDTH-1:0] ep_data;
  logic [KEEP_WIDTH-1:0] ep_keep;

  logic [DATA_WIDTH-1:0] hdr_data;
  logic [16:0]           beat_bytes;
  logic [16:0]           total_bytes;

  logic                  unused_reserved;
  assign unused_reserved = ^bus.s_notif_data[87:81];

  function automatic logic [16:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [16:0] c;
    c = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      c = c + {16'd0, k[i]};
    end
    return c;
  endfunction

  always_comb begin
    hdr_data        = '0;
    hdr_data[79:0]  = {port_q, ip_q, length_q, session_q};
  end

  assign beat_bytes  = popcount(bus.s_rxdata_keep);
  assign total_bytes = byte_cnt_q + beat_bytes;

  always_comb begin
    state_d       = state_q;
    session_d     = session_q;
    length_d      = length_q;
    ip_d          = ip_q;
    port_d        = port_q;
    byte_cnt_d    = byte_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_session_d = err_session_q;
    err_length_d  = err_length_q;

    notif_ready   = 1'b0;
    rp_valid      = 1'b0;
    rp_data       = '0;
    meta_ready    = 1'b0;
    rx_ready      = 1'b0;
    ep_valid      = 1'b0;
    ep_last       = 1'b0;
    ep_data       = '0;
    ep_keep       = '0;

    // Outputs are forced quiet while reset is held, so the cycle in which
    // reset is sampled never presents a valid or ready to a neighbour.
    if (net_aresetn) begin
      unique case (state_q)
        IDLE: begin
          notif_ready = 1'b1;
          if (bus.s_notif_valid) begin
            session_d = bus.s_notif_data[15:0];
            length_d  = bus.s_notif_data[31:16];
            ip_d      = bus.s_notif_data[63:32];
            port_d    = bus.s_notif_data[79:64];
            if (bus.s_notif_data[80] || (bus.s_notif_data[31:16] == 16'd0)) begin
              drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end else begin
              state_d = REQ;
            end
          end
        end

        REQ: begin
          rp_valid = 1'b1;
          rp_data  = {length_q, session_q};
          if (bus.m_readpkg_ready) begin
            state_d = META;
          end
        end

        META: begin
          meta_ready = 1'b1;
          if (bus.s_rxmeta_valid) begin
            if (bus.s_rxmeta_data != session_q) begin
              err_session_d = 1'b1;
            end
            state_d = HDR;
          end
        end

        HDR: begin
          ep_valid = 1'b1;
          ep_keep  = '1;
          ep_data  = hdr_data;
          if (bus.m_ep_ready) begin
            byte_cnt_d = '0;
            state_d    = DATA;
          end
        end

        DATA: begin
          ep_valid = bus.s_rxdata_valid;
          rx_ready = bus.m_ep_ready;
          ep_data  = bus.s_rxdata_data;
          ep_keep  = bus.s_rxdata_keep;
          ep_last  = bus.s_rxdata_last;
          if (bus.s_rxdata_valid && bus.m_ep_ready) begin
            byte_cnt_d = total_bytes;
            if (bus.s_rxdata_last) begin
              if (total_bytes != {1'b0, length_q}) begin
                err_length_d = 1'b1;
              end
              pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
              state_d   = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge net_clk) begin
    if (!net_aresetn) begin
      state_q       <= IDLE;
      session_q     <= '0;
      length_q      <= '0;
      ip_q          <= '0;
      port_q        <= '0;
      byte_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      pkt_cnt_q     <= '0;
      err_session_q <= 1'b0;
      err_length_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      session_q     <= session_d;
      length_q      <= length_d;
      ip_q          <= ip_d;
      port_q        <= port_d;
      byte_cnt_q    <= byte_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      pkt_cnt_q     <= pkt_cnt_d;
      err_session_q <= err_session_d;
      err_length_q  <= err_length_d;
    end
  end

  assign bus.s_notif_ready   = notif_ready;
  assign bus.m_readpkg_valid = rp_valid;
  assign bus.m_readpkg_data  = rp_data;
  assign bus.s_rxmeta_ready  = meta_ready;
  assign bus.s_rxdata_ready  = rx_ready;
  assign bus.m_ep_valid      = ep_valid;
  assign bus.m_ep_last       = ep_last;
  assign bus.m_ep_data       = ep_data;
  assign bus.m_ep_keep       = ep_keep;

  assign drop_cnt    = drop_cnt_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign err_session = err_session_q;
  assign err_length  = err_length_q;

endmodule

// File: tb/tb_tcp_rx_session_reader.sv
// ----------------------------------------------------------------------------
// tb_tcp_rx_session_reader
//
// Drives notifications, metadata and payload into tcp_rx_session_reader and
// checks read-package requests and endpoint beats against a scoreboard of
// expected transfers, plus counters and sticky flags against a small model.
// ----------------------------------------------------------------------------
module tb_tcp_rx_session_reader;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned CW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          net_clk = 1'b0;
  logic          net_aresetn = 1'b0;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] pkt_cnt;
  logic          err_session;
  logic          err_length;

  always #5 net_clk = ~net_clk;

  tcp_rx_session_reader_if #(.DATA_WIDTH(DW)) bus ();

  tcp_rx_session_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .net_clk     (net_clk),
    .net_aresetn (net_aresetn),
    .bus         (bus),
    .drop_cnt    (drop_cnt),
    .pkt_cnt     (pkt_cnt),
    .err_session (err_session),
    .err_length  (err_length)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [CW-1:0] exp_drop = '0;
  logic [CW-1:0] exp_pkt  = '0;
  logic          exp_es   = 1'b0;
  logic          exp_el   = 1'b0;
  bit            rnd_ready = 1'b0;

  beat_t       ep_q[$];
  logic [31:0] rp_q[$];

  // --------------------------------------------------------------------------
  // Background processes
  // --------------------------------------------------------------------------
  task automatic monitor();
    bit            ep_stall = 1'b0;
    bit            rp_stall = 1'b0;
    bit            expect_rp = 1'b0;
    logic [DW-1:0] ep_prev_d;
    logic [KW-1:0] ep_prev_k;
    logic          ep_prev_l;
    logic [31:0]   rp_prev;
    beat_t         e;
    logic [31:0]   r;
    forever begin
      @(negedge net_clk);
      if (!net_aresetn) begin
        ep_stall  = 1'b0;
        rp_stall  = 1'b0;
        expect_rp = 1'b0;
        continue;
      end
      if (expect_rp) begin
        checks++;
        if (bus.m_readpkg_valid !== 1'b1) begin
          errors++;
          $display("FAIL readpkg_latency valid=%b expected 1", bus.m_readpkg_valid);
        end
        expect_rp = 1'b0;
      end
      if (ep_stall) begin
        checks++;
        if (bus.m_ep_valid !== 1'b1 || bus.m_ep_data !== ep_prev_d ||
            bus.m_ep_keep !== ep_prev_k || bus.m_ep_last !== ep_prev_l) begin
          errors++;
          $display("FAIL ep_hold valid=%b last=%b data_lo=%h expected valid=1 last=%b data_lo=%h",
                   bus.m_ep_valid, bus.m_ep_last, bus.m_ep_data[127:0], ep_prev_l, ep_prev_d[127:0]);
        end
      end
      if (rp_stall) begin
        checks++;
        if (bus.m_readpkg_valid !== 1'b1 || bus.m_readpkg_data !== rp_prev) begin
          errors++;
          $display("FAIL readpkg_hold valid=%b data=%h expected valid=1 data=%h",
                   bus.m_readpkg_valid, bus.m_readpkg_data, rp_prev);
        end
      end
      if (bus.m_ep_valid === 1'b1 && bus.m_ep_ready === 1'b1) begin
        checks++;
        if (ep_q.size() == 0) begin
          errors++;
          $display("FAIL ep_unexpected data_lo=%h expected no beat", bus.m_ep_data[127:0]);
        end else begin
          e = ep_q.pop_front();
          if (bus.m_ep_data !== e.data || bus.m_ep_keep !== e.keep || bus.m_ep_last !== e.last) begin
            errors++;
            $display("FAIL ep_beat data=%h keep=%h last=%b expected data=%h keep=%h last=%b",
                     bus.m_ep_data, bus.m_ep_keep, bus.m_ep_last, e.data, e.keep, e.last);
          end
        end
      end
      if (bus.m_readpkg_valid === 1'b1 && bus.m_readpkg_ready === 1'b1) begin
        checks++;
        if (rp_q.size() == 0) begin
          errors++;
          $display("FAIL readpkg_unexpected data=%h expected no request", bus.m_readpkg_data);
        end else begin
          r = rp_q.pop_front();
          if (bus.m_readpkg_data !== r) begin
            errors++;
            $display("FAIL readpkg_data data=%h expected %h", bus.m_readpkg_data, r);
          end
        end
      end
      if (bus.s_notif_valid === 1'b1 && bus.s_notif_ready === 1'b1 &&
          bus.s_notif_data[31:16] != 16'd0 && bus.s_notif_data[80] == 1'b0) begin
        expect_rp = 1'b1;
      end
      ep_stall  = (bus.m_ep_valid === 1'b1) && (bus.m_ep_ready !== 1'b1);
      ep_prev_d = bus.m_ep_data;
      ep_prev_k = bus.m_ep_keep;
      ep_prev_l = bus.m_ep_last;
      rp_stall  = (bus.m_readpkg_valid === 1'b1) && (bus.m_readpkg_ready !== 1'b1);
      rp_prev   = bus.m_readpkg_data;
    end
  endtask

  task automatic toggler();
    forever begin
      @(posedge net_clk);
      #1;
      if (rnd_ready) begin
        bus.m_ep_ready      = 1'($urandom_range(0, 1));
        bus.m_readpkg_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Channel drivers (each starts and ends just after a rising edge)
  // --------------------------------------------------------------------------
  task automatic drive_notif(input logic [87:0] d);
    int unsigned n = 0;
    bus.s_notif_data  = d;
    bus.s_notif_valid = 1'b1;
    @(negedge net_clk);
    while (bus.s_notif_ready !== 1'b1 && n < 200) begin
      @(negedge net_clk);
      n++;
    end
    if (bus.s_notif_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL notif_timeout ready=%b expected 1", bus.s_notif_ready);
    end
    @(posedge net_clk);
    #1;
    bus.s_notif_valid = 1'b0;
    bus.s_notif_data  = '0;
  endtask

  task automatic drive_meta(input logic [15:0] m);
    int unsigned n = 0;
    bus.s_rxmeta_data  = m;
    bus.s_rxmeta_valid = 1'b1;
    @(negedge net_clk);
    while (bus.s_rxmeta_ready !== 1'b1 && n < 300) begin
      @(negedge net_clk);
      n++;
    end
    if (bus.s_rxmeta_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL meta_timeout ready=%b expected 1", bus.s_rxmeta_ready);
    end
    @(posedge net_clk);
    #1;
    bus.s_rxmeta_valid = 1'b0;
    bus.s_rxmeta_data  = '0;
  endtask

  task automatic drive_data(input beat_t beats[$]);
    int unsigned n;
    foreach (beats[i]) begin
      n = 0;
      bus.s_rxdata_data  = beats[i].data;
      bus.s_rxdata_keep  = beats[i].keep;
      bus.s_rxdata_last  = beats[i].last;
      bus.s_rxdata_valid = 1'b1;
      @(negedge net_clk);
      while (bus.s_rxdata_ready !== 1'b1 && n < 400) begin
        @(negedge net_clk);
        n++;
      end
      if (bus.s_rxdata_ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL rxdata_timeout beat=%0d ready=%b expected 1", i, bus.s_rxdata_ready);
      end
      @(posedge net_clk);
      #1;
    end
    bus.s_rxdata_valid = 1'b0;
    bus.s_rxdata_last  = 1'b0;
    bus.s_rxdata_data  = '0;
    bus.s_rxdata_keep  = '0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  // Pushes the expected request, header and payload, drives all channels and
  // waits for the scoreboard to drain.
  task automatic run_packet(input logic [15:0] sess, input logic [15:0] len,
                            input logic [31:0] ip, input logic [15:0] port,
                            input logic [15:0] meta, input int nbeats,
                            input logic [KW-1:0] last_keep);
    beat_t       b;
    beat_t       beats[$];
    logic [DW-1:0] h;
    int unsigned n = 0;
    rp_q.push_back({len, sess});
    h        = '0;
    h[15:0]  = sess;
    h[31:16] = len;
    h[63:32] = ip;
    h[79:64] = port;
    b.data = h;
    b.keep = '1;
    b.last = 1'b0;
    ep_q.push_back(b);
    for (int i = 0; i < nbeats; i++) begin
      b.data = rand_data();
      b.keep = (i == nbeats - 1) ? last_keep : '1;
      b.last = (i == nbeats - 1);
      beats.push_back(b);
      ep_q.push_back(b);
    end
    fork
      drive_notif({7'd0, 1'b0, port, ip, len, sess});
      drive_meta(meta);
      drive_data(beats);
    join
    while ((ep_q.size() != 0 || rp_q.size() != 0) && n < 500) begin
      @(negedge net_clk);
      n++;
    end
    checks++;
    if (ep_q.size() != 0 || rp_q.size() != 0) begin
      errors++;
      $display("FAIL drain ep_left=%0d rp_left=%0d expected 0 0", ep_q.size(), rp_q.size());
      ep_q.delete();
      rp_q.delete();
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    net_aresetn = 1'b0;
    repeat (3) @(posedge net_clk);
    @(negedge net_clk);
    checks++;
    if ({bus.s_notif_ready, bus.m_readpkg_valid, bus.s_rxmeta_ready,
         bus.s_rxdata_ready, bus.m_ep_valid, bus.m_ep_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshake notif_rdy=%b rp_vld=%b meta_rdy=%b rx_rdy=%b ep_vld=%b ep_last=%b expected all 0",
               bus.s_notif_ready, bus.m_readpkg_valid, bus.s_rxmeta_ready,
               bus.s_rxdata_ready, bus.m_ep_valid, bus.m_ep_last);
    end
    checks++;
    if (bus.m_ep_data !== '0 || bus.m_ep_keep !== '0 || bus.m_readpkg_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_data ep_data_lo=%h ep_keep=%h rp_data=%h expected 0",
               bus.m_ep_data[127:0], bus.m_ep_keep, bus.m_readpkg_data);
    end
    checks++;
    if (drop_cnt !== '0 || pkt_cnt !== '0 || err_session !== 1'b0 || err_length !== 1'b0) begin
      errors++;
      $display("FAIL reset_status drop=%0d pkt=%0d es=%b el=%b expected 0 0 0 0",
               drop_cnt, pkt_cnt, err_session, err_length);
    end
    @(posedge net_clk);
    #1;
    net_aresetn = 1'b1;
    @(negedge net_clk);
    checks++;
    if (bus.s_notif_ready !== 1'b1 || bus.m_readpkg_valid !== 1'b0 || bus.m_ep_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset notif_rdy=%b rp_vld=%b ep_vld=%b expected 1 0 0",
               bus.s_notif_ready, bus.m_readpkg_valid, bus.m_ep_valid);
    end
    @(posedge net_clk);
    #1;
  endtask

  task automatic test_basic();
    run_packet(16'h0005, 16'd128, 32'h0A00_0001, 16'h1F90, 16'h0005, 2, '1);
    exp_pkt = exp_pkt + 1;
    checks++;
    if (pkt_cnt !== exp_pkt || err_session !== exp_es || err_length !== exp_el || drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL basic_status pkt=%0d es=%b el=%b drop=%0d expected %0d %b %b %0d",
               pkt_cnt, err_session, err_length, drop_cnt, exp_pkt, exp_es, exp_el, exp_drop);
    end
  endtask

  task automatic test_drops();
    drive_notif({7'd0, 1'b0, 16'h1234, 32'hC0A8_0001, 16'd0, 16'h0007});
    exp_drop = exp_drop + 1;
    @(negedge net_clk);
    checks++;
    if (bus.m_readpkg_valid !== 1'b0 || bus.s_notif_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_len0 rp_vld=%b notif_rdy=%b expected 0 1", bus.m_readpkg_valid, bus.s_notif_ready);
    end
    @(posedge net_clk);
    #1;
    drive_notif({7'd0, 1'b1, 16'h1234, 32'hC0A8_0001, 16'd64, 16'h0008});
    exp_drop = exp_drop + 1;
    repeat (3) begin
      @(negedge net_clk);
      checks++;
      if (bus.m_readpkg_valid !== 1'b0 || bus.s_notif_ready !== 1'b1) begin
        errors++;
        $display("FAIL drop_closed rp_vld=%b notif_rdy=%b expected 0 1", bus.m_readpkg_valid, bus.s_notif_ready);
      end
    end
    checks++;
    if (drop_cnt !== exp_drop || pkt_cnt !== exp_pkt) begin
      errors++;
      $display("FAIL drop_cnt drop=%0d pkt=%0d expected %0d %0d", drop_cnt, pkt_cnt, exp_drop, exp_pkt);
    end
    @(posedge net_clk);
    #1;
  endtask

  task automatic test_session_err();
    checks++;
    if (err_session !== 1'b0) begin
      errors++;
      $display("FAIL session_err_pre es=%b expected 0", err_session);
    end
    run_packet(16'h0005, 16'd128, 32'h0A00_0001, 16'h1F90, 16'h0006, 2, '1);
    exp_pkt = exp_pkt + 1;
    exp_es  = 1'b1;
    checks++;
    if (err_session !== exp_es || err_length !== exp_el || pkt_cnt !== exp_pkt) begin
      errors++;
      $display("FAIL session_err es=%b el=%b pkt=%0d expected %b %b %0d",
               err_session, err_length, pkt_cnt, exp_es, exp_el, exp_pkt);
    end
  endtask

  task automatic test_length_err();
    run_packet(16'h0010, 16'd100, 32'h0A00_0002, 16'h0050, 16'h0010, 2, 64'h0F);
    exp_pkt = exp_pkt + 1;
    exp_el  = 1'b1;
    checks++;
    if (err_length !== exp_el || err_session !== exp_es || pkt_cnt !== exp_pkt) begin
      errors++;
      $display("FAIL length_err el=%b es=%b pkt=%0d expected %b %b %0d",
               err_length, err_session, pkt_cnt, exp_el, exp_es, exp_pkt);
    end
  endtask

  task automatic test_stall();
    rnd_ready = 1'b1;
    run_packet(16'h0005, 16'd128, 32'h0A00_0001, 16'h1F90, 16'h0005, 2, '1);
    run_packet(16'h0021, 16'd260, 32'h0A00_0003, 16'h0BB8, 16'h0021, 5, 64'h0F);
    rnd_ready = 1'b0;
    @(posedge net_clk);
    #2;
    bus.m_ep_ready      = 1'b1;
    bus.m_readpkg_ready = 1'b1;
    exp_pkt = exp_pkt + 2;
    checks++;
    if (pkt_cnt !== exp_pkt || err_length !== exp_el || err_session !== exp_es) begin
      errors++;
      $display("FAIL stall_status pkt=%0d el=%b es=%b expected %0d %b %b",
               pkt_cnt, err_length, err_session, exp_pkt, exp_el, exp_es);
    end
  endtask

  task automatic test_reset_mid();
    beat_t b;
    beat_t one[$];
    logic [DW-1:0] h;
    rp_q.push_back({16'd128, 16'h0005});
    h        = '0;
    h[79:0]  = {16'h1F90, 32'h0A00_0001, 16'd128, 16'h0005};
    b.data = h;
    b.keep = '1;
    b.last = 1'b0;
    ep_q.push_back(b);
    b.data = rand_data();
    one.push_back(b);
    ep_q.push_back(b);
    fork
      drive_notif({7'd0, 1'b0, 16'h1F90, 32'h0A00_0001, 16'd128, 16'h0005});
      drive_meta(16'h0005);
    join
    drive_data(one);
    // Second beat offered but stalled; reset lands while in DATA.
    bus.m_ep_ready     = 1'b0;
    bus.s_rxdata_data  = rand_data();
    bus.s_rxdata_keep  = '1;
    bus.s_rxdata_last  = 1'b1;
    bus.s_rxdata_valid = 1'b1;
    net_aresetn        = 1'b0;
    @(posedge net_clk);
    #1;
    net_aresetn        = 1'b1;
    bus.s_rxdata_valid = 1'b0;
    bus.s_rxdata_last  = 1'b0;
    bus.m_ep_ready     = 1'b1;
    exp_drop = '0;
    exp_pkt  = '0;
    exp_es   = 1'b0;
    exp_el   = 1'b0;
    @(negedge net_clk);
    checks++;
    if (bus.m_ep_valid !== 1'b0 || bus.m_ep_last !== 1'b0 || bus.m_ep_data !== '0 ||
        bus.m_ep_keep !== '0 || bus.m_readpkg_valid !== 1'b0 || bus.s_rxmeta_ready !== 1'b0 ||
        bus.s_rxdata_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs ep_vld=%b ep_last=%b ep_keep=%h rp_vld=%b meta_rdy=%b rx_rdy=%b expected all 0",
               bus.m_ep_valid, bus.m_ep_last, bus.m_ep_keep, bus.m_readpkg_valid,
               bus.s_rxmeta_ready, bus.s_rxdata_ready);
    end
    checks++;
    if (drop_cnt !== exp_drop || pkt_cnt !== exp_pkt || err_session !== exp_es ||
        err_length !== exp_el || ep_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_status drop=%0d pkt=%0d es=%b el=%b ep_left=%0d expected 0 0 0 0 0",
               drop_cnt, pkt_cnt, err_session, err_length, ep_q.size());
      ep_q.delete();
    end
    @(posedge net_clk);
    #1;
    run_packet(16'h0005, 16'd128, 32'h0A00_0001, 16'h1F90, 16'h0005, 2, '1);
    exp_pkt = exp_pkt + 1;
    checks++;
    if (pkt_cnt !== exp_pkt || err_session !== exp_es || err_length !== exp_el || drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL post_reset_packet pkt=%0d es=%b el=%b drop=%0d expected %0d %b %b %0d",
               pkt_cnt, err_session, err_length, drop_cnt, exp_pkt, exp_es, exp_el, exp_drop);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    bus.s_notif_valid   = 1'b0;
    bus.s_notif_data    = '0;
    bus.m_readpkg_ready = 1'b1;
    bus.s_rxmeta_valid  = 1'b0;
    bus.s_rxmeta_data   = '0;
    bus.s_rxdata_valid  = 1'b0;
    bus.s_rxdata_last   = 1'b0;
    bus.s_rxdata_data   = '0;
    bus.s_rxdata_keep   = '0;
    bus.m_ep_ready      = 1'b1;

    fork
      monitor();
      toggler();
      begin
        #200000;
        $display("FAIL watchdog time=%0t expected completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
      end
    join_none

    test_reset();
    test_basic();
    test_drops();
    test_session_err();
    test_length_err();
    test_stall();
    test_reset_mid();

    repeat (2) @(posedge net_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
